// File: rtl/inst_load_sequencer.sv
// -----------------------------------------------------------------------------
// inst_load_sequencer
//
// Loads a program into the instruction memory of inst_control. A burst
// descriptor (base address, instruction count, autostart bit) is taken on
// cfg_start_i. The block then issues one write-address strobe and forwards
// the instruction stream as write-data strobes. It finishes with a
// program-counter reset pulse and, if requested, a core start pulse.
//
// Stream handshake: a beat transfers on every clk_i rising edge where
// inst_valid_i and inst_ready_o are both high. inst_ready_o is high only in
// STREAM. The producer may hold or drop inst_valid_i freely. Data offered
// outside STREAM is never consumed.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   clr_i                synchronous abort/clear, highest priority
//   cfg_start_i          launch pulse, sampled only in IDLE
//   cfg_base_addr_i      first instruction memory address
//   cfg_num_inst_i       instruction count, 0..InstMemDepth
//   cfg_autostart_i      fire core_start_o after the load
//   core_enable_i        inst_control enable; a running core rejects loads
//   inst_data_i/valid_i  instruction stream in
//   inst_ready_o         instruction stream ready
//   inst_wr_*_o          write-mode / address / data strobes to inst_control
//   inst_pc_reset_o      program-counter reset pulse
//   core_start_o         core start pulse
//   busy_o, done_o, err_o, loaded_cnt_o   status
// -----------------------------------------------------------------------------
module inst_load_sequencer #(
    parameter int RegAddrWidth     = 32,
    parameter int InstMemDepth     = 128,
    parameter int InstMemAddrWidth = $clog2(InstMemDepth)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        cfg_start_i,
    input  logic [InstMemAddrWidth-1:0] cfg_base_addr_i,
    input  logic [InstMemAddrWidth:0]   cfg_num_inst_i,
    input  logic                        cfg_autostart_i,
    input  logic                        core_enable_i,
    input  logic [RegAddrWidth-1:0]     inst_data_i,
    input  logic                        inst_valid_i,
    output logic                        inst_ready_o,
    output logic                        inst_wr_mode_o,
    output logic [InstMemAddrWidth-1:0] inst_wr_addr_o,
    output logic                        inst_wr_addr_en_o,
    output logic [RegAddrWidth-1:0]     inst_wr_data_o,
    output logic                        inst_wr_data_en_o,
    output logic                        inst_pc_reset_o,
    output logic                        core_start_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [InstMemAddrWidth:0]   loaded_cnt_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETADDR = 3'd1,
        STREAM  = 3'd2,
        FINISH  = 3'd3,
        LAUNCH  = 3'd4
    } state_t;

    localparam logic [InstMemAddrWidth:0] DEPTH = (InstMemAddrWidth+1)'(InstMemDepth);
    localparam logic [InstMemAddrWidth:0] ONE   = 1;

    state_t                      state_q, state_d;
    logic [InstMemAddrWidth-1:0] base_q;
    logic [InstMemAddrWidth:0]   remaining_q;
    logic [InstMemAddrWidth:0]   loaded_q;
    logic                        autostart_q;
    logic                        done_q;
    logic                        err_q;

    // One bit wider than the address, so base + count never wraps.
    logic [InstMemAddrWidth:0]   end_addr;
    logic                        reject;

    assign end_addr = {1'b0, cfg_base_addr_i} + cfg_num_inst_i;
    assign reject   = core_enable_i || (end_addr > DEPTH);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        inst_ready_o      = 1'b0;
        inst_wr_mode_o    = 1'b0;
        inst_wr_addr_o    = '0;
        inst_wr_addr_en_o = 1'b0;
        inst_wr_data_o    = '0;
        inst_wr_data_en_o = 1'b0;
        inst_pc_reset_o   = 1'b0;
        core_start_o      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start_i && !reject) begin
                    state_d = (cfg_num_inst_i == '0) ? FINISH : SETADDR;
                end
            end
            SETADDR: begin
                inst_wr_mode_o    = 1'b1;
                inst_wr_addr_en_o = 1'b1;
                inst_wr_addr_o    = base_q;
                state_d           = STREAM;
            end
            STREAM: begin
                // inst_control auto-increments its write pointer on every
                // data strobe, so the strobe simply follows the stream valid.
                inst_wr_mode_o    = 1'b1;
                inst_ready_o      = 1'b1;
                inst_wr_data_en_o = inst_valid_i;
                inst_wr_data_o    = inst_data_i;
                if (inst_valid_i && remaining_q == ONE) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                inst_pc_reset_o = 1'b1;
                state_d         = autostart_q ? LAUNCH : IDLE;
            end
            LAUNCH: begin
                core_start_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over any transition, including a start in IDLE.
        if (clr_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            base_q      <= '0;
            remaining_q <= '0;
            loaded_q    <= '0;
            autostart_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (clr_i) begin
            base_q      <= '0;
            remaining_q <= '0;
            loaded_q    <= '0;
            autostart_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (state_q == IDLE && cfg_start_i) begin
                done_q   <= 1'b0;
                loaded_q <= '0;
                err_q    <= reject;
                if (!reject) begin
                    base_q      <= cfg_base_addr_i;
                    remaining_q <= cfg_num_inst_i;
                    autostart_q <= cfg_autostart_i;
                end
            end
            if (state_q == STREAM && inst_valid_i) begin
                remaining_q <= remaining_q - ONE;
                loaded_q    <= loaded_q + ONE;
            end
            if (state_q == FINISH) begin
                done_q <= 1'b1;
            end
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign loaded_cnt_o = loaded_q;

endmodule

// File: tb/tb_inst_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inst_load_sequencer
//
// Driver tasks issue load descriptors and instruction streams. When a load is
// issued, its expected memory writes ({address, data}) and its expected
// pulse events go into queues. An independent monitor models inst_control's
// write pointer (address strobe loads it, each data strobe writes and then
// increments it). It pops and compares whenever the DUT strobes a write or
// pulses pc_reset / core_start. Drivers check status timing directly against
// the cycle schedule of a load.
// -----------------------------------------------------------------------------
module tb_inst_load_sequencer;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam logic [1:0] EV_PCRST = 2'b01;
    localparam logic [1:0] EV_START = 2'b10;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_i;
    logic          cfg_start_i;
    logic [AW-1:0] cfg_base_addr_i;
    logic [AW:0]   cfg_num_inst_i;
    logic          cfg_autostart_i;
    logic          core_enable_i;
    logic [DW-1:0] inst_data_i;
    logic          inst_valid_i;
    logic          inst_ready_o;
    logic          inst_wr_mode_o;
    logic [AW-1:0] inst_wr_addr_o;
    logic          inst_wr_addr_en_o;
    logic [DW-1:0] inst_wr_data_o;
    logic          inst_wr_data_en_o;
    logic          inst_pc_reset_o;
    logic          core_start_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [AW:0]   loaded_cnt_o;

    int vectors     = 0;
    int miscompares = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [1:0]       exp_evt_q[$];

    inst_load_sequencer dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .clr_i             (clr_i),
        .cfg_start_i       (cfg_start_i),
        .cfg_base_addr_i   (cfg_base_addr_i),
        .cfg_num_inst_i    (cfg_num_inst_i),
        .cfg_autostart_i   (cfg_autostart_i),
        .core_enable_i     (core_enable_i),
        .inst_data_i       (inst_data_i),
        .inst_valid_i      (inst_valid_i),
        .inst_ready_o      (inst_ready_o),
        .inst_wr_mode_o    (inst_wr_mode_o),
        .inst_wr_addr_o    (inst_wr_addr_o),
        .inst_wr_addr_en_o (inst_wr_addr_en_o),
        .inst_wr_data_o    (inst_wr_data_o),
        .inst_wr_data_en_o (inst_wr_data_en_o),
        .inst_pc_reset_o   (inst_pc_reset_o),
        .core_start_o      (core_start_o),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .loaded_cnt_o      (loaded_cnt_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [AW-1:0]    ptr;
        logic [AW+DW-1:0] exp_w;
        logic [1:0]       act_ev;
        ptr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (inst_wr_addr_en_o) ptr = inst_wr_addr_o;
                if (inst_wr_data_en_o) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                                 ptr, inst_wr_data_o);
                    end else begin
                        exp_w = exp_q.pop_front();
                        check("mem_write", {ptr, inst_wr_data_o}, exp_w);
                        check("wr_mode_on_write", inst_wr_mode_o, 1'b1);
                    end
                    ptr = ptr + 1'b1;
                end
                act_ev = {core_start_o, inst_pc_reset_o};
                if (act_ev != 2'b00) begin
                    if (exp_evt_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_pulse: got %0h, expected none", act_ev);
                    end else begin
                        check("pulse_event", act_ev, exp_evt_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Accepted load. gap_mode: 0 continuous, 1 alternating valid, 2 random.
    task automatic do_load(input int base, input int n, input bit auto_s,
                           input int gap_mode, input bit seq_data);
        logic [DW-1:0] d[$];
        logic [DW-1:0] w;
        logic          v;
        int            sent;
        int            k;
        for (int i = 0; i < n; i++) begin
            w = seq_data ? (32'hA0 + 32'(i)) : $urandom;
            d.push_back(w);
            exp_q.push_back({AW'(base + i), w});
        end
        exp_evt_q.push_back(EV_PCRST);
        if (auto_s) exp_evt_q.push_back(EV_START);

        cfg_base_addr_i = AW'(base);
        cfg_num_inst_i  = (AW+1)'(n);
        cfg_autostart_i = auto_s;
        cfg_start_i     = 1'b1;
        step();                                   // cycle 1
        cfg_start_i     = 1'b0;
        cfg_autostart_i = 1'($urandom_range(0, 1));
        check("err_after_accept", err_o, 1'b0);
        check("done_cleared", done_o, 1'b0);
        check("loaded_cleared", loaded_cnt_o, 0);
        if (n > 0) begin
            check("busy_setaddr", busy_o, 1'b1);
            check("ready_setaddr", inst_ready_o, 1'b0);
            // Offered data in SETADDR must not be taken.
            inst_valid_i = 1'b1;
            inst_data_i  = $urandom;
            step();                               // cycle 2: stream
            sent = 0;
            k    = 0;
            while (sent < n) begin
                if (gap_mode == 0)      v = 1'b1;
                else if (gap_mode == 1) v = (k % 2 == 0);
                else                    v = ($urandom_range(0, 2) != 0);
                inst_valid_i = v;
                inst_data_i  = v ? d[sent] : $urandom;
                @(posedge clk);
                if (v) sent++;
                k++;
                #1;
            end
            inst_valid_i = 1'b0;
        end
        // FINISH cycle
        check("pc_reset_in_finish", inst_pc_reset_o, 1'b1);
        check("done_low_in_finish", done_o, 1'b0);
        check("wr_mode_low_finish", inst_wr_mode_o, 1'b0);
        check("ready_low_finish", inst_ready_o, 1'b0);
        step();
        check("done_set", done_o, 1'b1);
        check("loaded_cnt", loaded_cnt_o, 64'(n));
        check("core_start_after_finish", core_start_o, auto_s);
        if (auto_s) begin
            step();
            check("core_start_single", core_start_o, 1'b0);
        end
        check("busy_back_idle", busy_o, 1'b0);
    endtask

    task automatic do_reject(input int base, input int n, input bit core_en);
        cfg_base_addr_i = AW'(base);
        cfg_num_inst_i  = (AW+1)'(n);
        cfg_autostart_i = 1'b1;
        core_enable_i   = core_en;
        cfg_start_i     = 1'b1;
        step();
        cfg_start_i   = 1'b0;
        core_enable_i = 1'b0;
        check("err_on_reject", err_o, 1'b1);
        check("busy_on_reject", busy_o, 1'b0);
        inst_valid_i = 1'b1;
        inst_data_i  = $urandom;
        for (int i = 0; i < 2; i++) begin
            step();
            check("ready_after_reject", inst_ready_o, 1'b0);
            check("busy_after_reject", busy_o, 1'b0);
        end
        inst_valid_i = 1'b0;
    endtask

    task automatic do_abort(input int base);
        logic [DW-1:0] w;
        exp_q.delete();
        cfg_base_addr_i = AW'(base);
        cfg_num_inst_i  = 8'd5;
        cfg_autostart_i = 1'b1;
        cfg_start_i     = 1'b1;
        step();
        cfg_start_i = 1'b0;
        step();                                   // cycle 2: stream
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            exp_q.push_back({AW'(base + i), w});
            inst_valid_i = 1'b1;
            inst_data_i  = w;
            step();
        end
        inst_valid_i = 1'b0;
        clr_i        = 1'b1;
        step();
        clr_i = 1'b0;
        check("abort_busy", busy_o, 1'b0);
        check("abort_ready", inst_ready_o, 1'b0);
        check("abort_done", done_o, 1'b0);
        check("abort_loaded", loaded_cnt_o, 0);
        repeat (3) step();
        check("abort_done_stays", done_o, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : driver
        int base;
        int n;
        int maxn;
        rst             = 1'b1;
        clr_i           = 1'b0;
        cfg_start_i     = 1'b0;
        cfg_base_addr_i = '0;
        cfg_num_inst_i  = '0;
        cfg_autostart_i = 1'b0;
        core_enable_i   = 1'b0;
        inst_data_i     = '0;
        inst_valid_i    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {inst_ready_o, inst_wr_mode_o, inst_wr_addr_o, inst_wr_addr_en_o,
               inst_wr_data_en_o, inst_pc_reset_o, core_start_o, busy_o, done_o,
               err_o, loaded_cnt_o}, 0);
        check("reset_wr_data", inst_wr_data_o, 0);
        rst = 1'b0;
        step();

        do_load(0, 4, 1'b0, 0, 1'b1);             // continuous, 0xA0..0xA3
        repeat (3) step();
        check("done_sticky", done_o, 1'b1);
        do_load(10, 3, 1'b0, 1, 1'b0);            // gapped 1,0,1,0,1
        do_reject(120, 10, 1'b0);                 // overflow
        do_reject(5, 3, 1'b1);                    // core running
        do_load(127, 1, 1'b0, 0, 1'b0);           // ends exactly at depth
        do_load(0, 2, 1'b1, 0, 1'b0);             // autostart
        do_abort(20);
        do_load(3, 0, 1'b0, 0, 1'b0);             // zero length

        // start and clear together: start dropped
        cfg_base_addr_i = 7'd1;
        cfg_num_inst_i  = 8'd4;
        cfg_start_i     = 1'b1;
        clr_i           = 1'b1;
        step();
        cfg_start_i = 1'b0;
        clr_i       = 1'b0;
        check("start_clr_busy", busy_o, 1'b0);
        check("start_clr_done", done_o, 1'b0);
        step();

        for (int it = 0; it < 30; it++) begin
            base = $urandom_range(0, 127);
            if ($urandom_range(0, 3) == 0) begin
                if (base == 0 || $urandom_range(0, 1) == 0)
                    do_reject(base, $urandom_range(0, 128 - base), 1'b1);
                else
                    do_reject(base, $urandom_range(129 - base, 128), 1'b0);
            end else begin
                maxn = (128 - base < 12) ? 128 - base : 12;
                n = $urandom_range(0, maxn);
                do_load(base, n, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
            end
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (4) step();
        check("write_queue_drained", exp_q.size(), 0);
        check("event_queue_drained", exp_evt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_load_sequencer.md
# inst_load_sequencer

Sequences the loading of a program into the instruction memory inside `inst_control`. It accepts a burst descriptor (base address and instruction count) and a valid/ready instruction stream. It then drives `inst_control`'s write-mode, write-address and write-data strobes and resets the program counter. Optionally, it fires the core start pulse once loading completes. It sits between the host/CSR side and `inst_control`, replacing hand-toggled CSR write sequences.

## Interface
- `RegAddrWidth`, 32, instruction word width; matches `inst_control`.
- `InstMemDepth`, 128, number of instruction memory entries.
- `InstMemAddrWidth`, `$clog2(InstMemDepth)`, derived; do not override.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Single clock domain; reset is asynchronous and active-high.
- `clr_i` in 1: synchronous abort/clear.
- `cfg_start_i` in 1: pulse that launches a load.
- `cfg_base_addr_i` in `InstMemAddrWidth`: first write address.
- `cfg_num_inst_i` in `InstMemAddrWidth+1`: instruction count, 0..`InstMemDepth`.
- `cfg_autostart_i` in 1: pulse `core_start_o` after the load.
- `core_enable_i` in 1: `enable_o` from `inst_control`.
- `inst_data_i` in `RegAddrWidth`: stream data.
- `inst_valid_i` in 1: stream valid.
- `inst_ready_o` out 1: stream ready.
- `inst_wr_mode_o` out 1: connects to `inst_control` `inst_wr_mode_i`.
- `inst_wr_addr_o` out `InstMemAddrWidth`: write address.
- `inst_wr_addr_en_o` out 1: write-address strobe.
- `inst_wr_data_o` out `RegAddrWidth`: write data.
- `inst_wr_data_en_o` out 1: write-data strobe.
- `inst_pc_reset_o` out 1: program-counter reset pulse.
- `core_start_o` out 1: core start pulse.
- `busy_o` out 1: high when not in IDLE.
- `done_o` out 1: sticky load-complete flag.
- `err_o` out 1: sticky rejected-descriptor flag.
- `loaded_cnt_o` out `InstMemAddrWidth+1`: beats written in the current or last load.

## Operation
- FSM states: IDLE, SETADDR, STREAM, FINISH, LAUNCH.
- **IDLE:** `cfg_start_i` is sampled here. On acceptance, the block clears `done_o`, `err_o` and `loaded_cnt_o`.
  - Reject when `core_enable_i`=1 or `cfg_base_addr_i + cfg_num_inst_i > InstMemDepth`. The sum is computed at `InstMemAddrWidth+1` bits, so it cannot wrap. On reject: set `err_o` and stay in IDLE. No write strobes are issued.
  - If `cfg_num_inst_i`=0, go directly to FINISH.
  - Otherwise, latch base and count into registers, then go to SETADDR.
- **SETADDR (1 cycle):** `inst_wr_mode_o`=1, `inst_wr_addr_en_o`=1, `inst_wr_addr_o`=latched base. Next state is STREAM.
- **STREAM:**
  - `inst_wr_mode_o`=1, `inst_ready_o`=1.
  - `inst_wr_data_en_o` = `inst_valid_i` (combinational), and `inst_wr_data_o` = `inst_data_i`.
  - Each beat where valid and ready are both high decrements the remaining count and increments `loaded_cnt_o`.
  - On the beat where remaining count = 1, go to FINISH.
  - `inst_control` auto-increments its PC on each data strobe, so the sequencer never re-issues an address.
- **FINISH (1 cycle):**
  - `inst_wr_mode_o`=0 and `inst_pc_reset_o`=1; `done_o` sets at the next edge.
  - If the latched autostart bit is set, go to LAUNCH; otherwise go to IDLE.
  - The autostart bit is latched with the descriptor.
- **LAUNCH (1 cycle):** `core_start_o`=1, then return to IDLE.
- `cfg_start_i` is ignored outside IDLE.
- `clr_i` has priority over everything:
  - Forces IDLE at the next edge.
  - Clears `done_o`, `err_o`, `loaded_cnt_o` and the internal counters.
  - No `inst_pc_reset_o` or `core_start_o` pulse is issued. `inst_control` handles its own `clr_i`.
- `inst_ready_o` is 0 in every state except STREAM.
- Stream data presented outside STREAM is not consumed.

## Timing
- During reset, all outputs are 0 and the state is IDLE.
- Outputs are registered-state decodes, except `inst_wr_data_en_o` and `inst_wr_data_o`, which are combinational from the stream inputs during STREAM.
- Cycle 0: `cfg_start_i` is accepted.
- Cycle 1: SETADDR.
- Cycle 2 onward: STREAM. With continuous valid, N beats occupy cycles 2..N+1.
- Cycle N+2: FINISH.
- Cycle N+3: `done_o`=1; `core_start_o`=1 if autostart is set.
- Total latency from start to `done_o` is N+3 cycles, with no bubbles. Each gap in `inst_valid_i` adds one cycle.
- An error (`err_o`) is visible the cycle after the rejected `cfg_start_i`.
- When `cfg_start_i` and `clr_i` arrive in the same cycle, `clr_i` wins and the start is dropped.
- `core_enable_i` is checked only at acceptance.

## Test plan
- **Continuous load:** base=0, N=4, continuous valid, data 0xA0..0xA3, no autostart.
  - Addr strobe at cycle 1; data strobes at cycles 2–5.
  - `pc_reset` at cycle 6; `done_o`=1 and `loaded_cnt_o`=4 at cycle 7.
  - Read-back through `inst_control` returns memory[0..3] = 0xA0..0xA3.
- **Gapped stream:** base=10, N=3, valid toggling 1,0,1,0,1.
  - Exactly 3 data strobes; entries 10..12 written.
  - FINISH at cycle 7.
- **Rejects:** base=120, N=10, depth 128 → `err_o`=1 next cycle, zero write strobes, `busy_o` stays 0. Repeat with `core_enable_i`=1 → same reject behaviour.
- **Autostart:** N=2, `cfg_autostart_i`=1.
  - `core_start_o` is a single-cycle pulse immediately after the `pc_reset` cycle.
  - `inst_control` `enable_o` rises, with PC=0.
- **Abort mid-stream:** `clr_i` after 2 of 5 beats.
  - IDLE next cycle; `inst_ready_o`=0.
  - `done_o`=0, `loaded_cnt_o`=0; no `pc_reset` or start pulse.
- **Zero-length load:** N=0 → FINISH at cycle 1, `done_o` at cycle 2, no write strobes.
